// File: rtl/undertale_pkg.sv
// Shared game definitions: battle status code, pixel coordinate type, arena
// bounds (also used by the soul movement block) and the pellet direction table.
package undertale_pkg;

  localparam logic [3:0] STATUS_BATTLE = 4'd5;

  typedef logic [9:0] coord_t;

  // Kill bounds: a pellet dies once x < ARENA_L, x >= ARENA_R or y >= ARENA_B.
  localparam int ARENA_L = 240;
  localparam int ARENA_R = 400;
  localparam int ARENA_B = 400;

  // Horizontal step of a pellet, signed pixels per frame.
  typedef logic signed [2:0] dx_t;

  // Fan of spawn directions, cycled in order.
  localparam int N_DIRS = 5;
  typedef logic [2:0] dir_idx_t;

  // State held by one pellet slot.
  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
    dx_t    dx;
  } slot_t;

  // Direction table {-2,-1,0,+1,+2}.
  function automatic dx_t dx_of(input dir_idx_t idx);
    case (idx)
      3'd0:    return dx_t'(-2);
      3'd1:    return dx_t'(-1);
      3'd2:    return dx_t'(0);
      3'd3:    return dx_t'(1);
      3'd4:    return dx_t'(2);
      default: return dx_t'(0);
    endcase
  endfunction

endpackage

// File: rtl/bullet_spawner_if.sv
// Game-side bundle of the bullet spawner: game state, soul position and pixel
// scan inputs, plus the per-pixel sprite outputs, hit pulse and live count.
interface bullet_spawner_if #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 4
);
  import undertale_pkg::*;

  logic [3:0]        status;
  logic              start_bullet;
  coord_t            soul_x;
  coord_t            soul_y;
  coord_t            DrawX;
  coord_t            DrawY;
  logic              is_bullet;
  logic [ADDR_W-1:0] bullet_address;
  logic              hit;
  logic [CNT_W-1:0]  bullet_count;

  // Game logic / video side.
  modport master (
    output status, start_bullet, soul_x, soul_y, DrawX, DrawY,
    input  is_bullet, bullet_address, hit, bullet_count
  );

  // The spawner itself.
  modport slave (
    input  status, start_bullet, soul_x, soul_y, DrawX, DrawY,
    output is_bullet, bullet_address, hit, bullet_count
  );

endinterface

// File: rtl/bullet_slot.sv
// One pellet of the pool: holds position and direction, moves it each active
// frame, retires it when it leaves the arena or touches the soul, and reports
// whether the current scan pixel falls inside its sprite box.
module bullet_slot
  import undertale_pkg::*;
#(
  parameter int SPEED       = 2,
  parameter int BULLET_SIZE = 8,
  parameter int SOUL_SIZE   = 16,
  parameter int SPAWN_X     = 316,
  parameter int SPAWN_Y     = 210,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active_i,
  input  logic              load_i,
  input  dx_t               load_dx_i,
  input  coord_t            soul_x_i,
  input  coord_t            soul_y_i,
  input  coord_t            draw_x_i,
  input  coord_t            draw_y_i,
  output logic              valid_o,
  output logic              killed_o,
  output logic              hit_o,
  output logic              match_o,
  output logic [ADDR_W-1:0] addr_o
);

  // Signed and one bit wider than needed, so a pellet drifting left of x=0
  // reads as negative and soul_x+SOUL_SIZE never wraps.
  typedef logic signed [11:0] pos_t;

  localparam pos_t       SPEED_P = pos_t'(SPEED);
  localparam pos_t       BSZ_P   = pos_t'(BULLET_SIZE);
  localparam pos_t       SOUL_P  = pos_t'(SOUL_SIZE);
  localparam pos_t       L_P     = pos_t'(ARENA_L);
  localparam pos_t       R_P     = pos_t'(ARENA_R);
  localparam pos_t       B_P     = pos_t'(ARENA_B);
  localparam logic [10:0] BSZ_U  = 11'(BULLET_SIZE);

  slot_t       slot_q, slot_d;
  pos_t        x_mv, y_mv, sx, sy;
  logic        out_of_arena, overlap;
  logic [10:0] off_x, off_y;

  // Moved position, arena kill test and soul overlap test for this frame.
  always_comb begin
    x_mv         = $signed({2'b00, slot_q.x}) + $signed({{9{slot_q.dx[2]}}, slot_q.dx});
    y_mv         = $signed({2'b00, slot_q.y}) + SPEED_P;
    sx           = $signed({2'b00, soul_x_i});
    sy           = $signed({2'b00, soul_y_i});
    out_of_arena = (x_mv < L_P) || (x_mv >= R_P) || (y_mv >= B_P);
    overlap      = (x_mv < sx + SOUL_P) && (sx < x_mv + BSZ_P) &&
                   (y_mv < sy + SOUL_P) && (sy < y_mv + BSZ_P);
    killed_o     = slot_q.valid && out_of_arena;
    hit_o        = slot_q.valid && !out_of_arena && overlap;
  end

  // Next slot state: clear when idle, load on spawn, otherwise move or retire.
  always_comb begin
    // NOTE: default every variable first so no path leaves one unassigned and infers a latch.
    slot_d = slot_q;
    if (!active_i) begin
      slot_d.valid = 1'b0;
    end else if (load_i) begin
      slot_d.valid = 1'b1;
      slot_d.x     = coord_t'(SPAWN_X);
      slot_d.y     = coord_t'(SPAWN_Y);
      slot_d.dx    = load_dx_i;
    end else if (slot_q.valid) begin
      slot_d.x     = x_mv[9:0];
      slot_d.y     = y_mv[9:0];
      slot_d.valid = !(out_of_arena || overlap);
    end
  end

  // Slot register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking (<=) so every flop samples pre-edge values; blocking (=) stays in always_comb.
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  // Scan-pixel hit test; a pixel left/above the box wraps to a large offset.
  always_comb begin
    off_x   = {1'b0, draw_x_i} - {1'b0, slot_q.x};
    off_y   = {1'b0, draw_y_i} - {1'b0, slot_q.y};
    match_o = slot_q.valid && (off_x < BSZ_U) && (off_y < BSZ_U);
    addr_o  = ADDR_W'(off_y) * ADDR_W'(BULLET_SIZE) + ADDR_W'(off_x);
  end

  assign valid_o = slot_q.valid;

endmodule

// File: rtl/bullet_spawner.sv
// Flower bullet attack: a pool of pellet slots spawned in a rotating fan on a
// fixed frame period, with a one-frame hit pulse, a live-pellet count and a
// per-pixel sprite lookup for the color mapper.
module bullet_spawner
  import undertale_pkg::*;
#(
  parameter int N_BULLETS    = 8,
  parameter int SPAWN_PERIOD = 30,
  parameter int SPEED        = 2,
  parameter int BULLET_SIZE  = 8,
  parameter int SOUL_SIZE    = 16,
  parameter int SPAWN_X      = 316,
  parameter int SPAWN_Y      = 210
) (
  input logic             frame_clk,
  input logic             Reset,
  bullet_spawner_if.slave bus
);

  localparam int ADDR_W = $clog2(BULLET_SIZE * BULLET_SIZE);
  localparam int CNT_W  = $clog2(N_BULLETS + 1);
  localparam int SC_W   = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [SC_W-1:0] SC_RELOAD = SC_W'(SPAWN_PERIOD - 1);

  logic                 active;
  logic [N_BULLETS-1:0] valid, killed_v, hit_v, match_v;
  logic [N_BULLETS-1:0] first_free, load, valid_next;
  logic                 any_free, spawn_now, any_match;
  logic [ADDR_W-1:0]    addr_v [N_BULLETS];
  logic [ADDR_W-1:0]    addr_sel;
  dx_t                  load_dx;

  logic [SC_W-1:0]      spawn_cnt_q, spawn_cnt_d;
  dir_idx_t             dir_q, dir_d;
  logic                 hit_q, hit_d;
  logic [CNT_W-1:0]     count_q, count_d;

  assign active  = (bus.status == STATUS_BATTLE) && bus.start_bullet;
  assign load_dx = dx_of(dir_q);

  for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .SPEED      (SPEED),
      .BULLET_SIZE(BULLET_SIZE),
      .SOUL_SIZE  (SOUL_SIZE),
      .SPAWN_X    (SPAWN_X),
      .SPAWN_Y    (SPAWN_Y),
      .ADDR_W     (ADDR_W)
    ) u_slot (
      .clk      (frame_clk),
      .rst      (Reset),
      .active_i (active),
      .load_i   (load[g]),
      .load_dx_i(load_dx),
      .soul_x_i (bus.soul_x),
      .soul_y_i (bus.soul_y),
      .draw_x_i (bus.DrawX),
      .draw_y_i (bus.DrawY),
      .valid_o  (valid[g]),
      .killed_o (killed_v[g]),
      .hit_o    (hit_v[g]),
      .match_o  (match_v[g]),
      .addr_o   (addr_v[g])
    );
  end

  // Lowest slot that is free at the start of the frame; slots freed this
  // frame still read as valid here, so they are reused only next frame.
  always_comb begin
    first_free = '0;
    any_free   = 1'b0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (!valid[i] && !any_free) begin
        first_free[i] = 1'b1;
        any_free      = 1'b1;
      end
    end
    spawn_now = active && (spawn_cnt_q == '0) && any_free;
    load      = spawn_now ? first_free : '0;
  end

  // Spawn timer, fan direction, hit OR and post-update live count.
  always_comb begin
    spawn_cnt_d = spawn_cnt_q;
    dir_d       = dir_q;
    hit_d       = 1'b0;
    valid_next  = '0;
    if (active) begin
      hit_d      = |hit_v;
      valid_next = (valid & ~killed_v & ~hit_v) | load;
      if (spawn_cnt_q == '0) begin
        spawn_cnt_d = SC_RELOAD;
        // A full pool skips the spawn, so the fan does not advance.
        if (any_free) dir_d = (dir_q == dir_idx_t'(N_DIRS - 1)) ? '0 : dir_q + 1'b1;
      end else begin
        spawn_cnt_d = spawn_cnt_q - 1'b1;
      end
    end else begin
      spawn_cnt_d = '0;
      dir_d       = '0;
    end
    count_d = '0;
    for (int i = 0; i < N_BULLETS; i++) count_d = count_d + CNT_W'(valid_next[i]);
  end

  // Control registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      spawn_cnt_q <= '0;
      dir_q       <= '0;
      hit_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      spawn_cnt_q <= spawn_cnt_d;
      dir_q       <= dir_d;
      hit_q       <= hit_d;
      count_q     <= count_d;
    end
  end

  // Pixel priority mux: the lowest-index matching slot supplies the address.
  always_comb begin
    addr_sel  = '0;
    any_match = |match_v;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (match_v[i]) addr_sel = addr_v[i];
    end
  end

  assign bus.is_bullet      = (bus.status == STATUS_BATTLE) && any_match;
  assign bus.bullet_address = addr_sel;
  assign bus.hit            = hit_q;
  assign bus.bullet_count   = count_q;

endmodule

// File: tb/tb_bullet_spawner.sv
// Bench for bullet_spawner: dut_a runs the default 30-frame spawn period,
// dut_b a 1-frame period. A rule-level pellet model tracks both pools.
module tb_bullet_spawner;
  import undertale_pkg::*;

  localparam int NB = 8;

  typedef struct {
    bit valid;
    int x;
    int y;
    int dx;
  } mslot_t;

  typedef struct {
    int px;
    int py;
    int status;
    bit exp_is;
    int exp_addr;  // -1: address not compared
  } pvec_t;

  logic frame_clk;
  logic rst_a, rst_b;

  bullet_spawner_if bus_a ();
  bullet_spawner_if bus_b ();

  bullet_spawner #(.SPAWN_PERIOD(30)) dut_a (.frame_clk(frame_clk), .Reset(rst_a), .bus(bus_a));
  bullet_spawner #(.SPAWN_PERIOD(1))  dut_b (.frame_clk(frame_clk), .Reset(rst_b), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;

  mslot_t m_slot [2][NB];
  int     m_cnt [2];
  int     m_dir [2];
  bit     m_hit [2];
  int     m_period [2];

  int in_st [2];
  bit in_start [2];
  int in_sx [2];
  int in_sy [2];

  pvec_t ptab [9];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dx_rule(input int i);
    case (i)
      0: return -2;
      1: return -1;
      2: return 0;
      3: return 1;
      default: return 2;
    endcase
  endfunction

  // ---------------- reference model ----------------
  task automatic m_reset(input int k);
    for (int i = 0; i < NB; i++) m_slot[k][i].valid = 0;
    m_cnt[k] = 0;
    m_dir[k] = 0;
    m_hit[k] = 0;
  endtask

  task automatic m_step(input int k);
    int free_slot;
    free_slot = -1;
    for (int i = 0; i < NB; i++)
      if (free_slot < 0 && !m_slot[k][i].valid) free_slot = i;
    m_hit[k] = 0;
    if (!(in_st[k] == 5 && in_start[k])) begin
      m_reset(k);
      return;
    end
    for (int i = 0; i < NB; i++) begin
      if (m_slot[k][i].valid) begin
        m_slot[k][i].x += m_slot[k][i].dx;
        m_slot[k][i].y += 2;
        if (m_slot[k][i].x < 240 || m_slot[k][i].x >= 400 || m_slot[k][i].y >= 400)
          m_slot[k][i].valid = 0;
        else if (m_slot[k][i].x < in_sx[k] + 16 && in_sx[k] < m_slot[k][i].x + 8 &&
                 m_slot[k][i].y < in_sy[k] + 16 && in_sy[k] < m_slot[k][i].y + 8) begin
          m_slot[k][i].valid = 0;
          m_hit[k] = 1;
        end
      end
    end
    if (m_cnt[k] == 0) begin
      if (free_slot >= 0) begin
        m_slot[k][free_slot] = '{1, 316, 210, dx_rule(m_dir[k])};
        m_dir[k] = (m_dir[k] + 1) % 5;
      end
      m_cnt[k] = m_period[k] - 1;
    end else begin
      m_cnt[k]--;
    end
  endtask

  function automatic int m_count(input int k);
    int c = 0;
    for (int i = 0; i < NB; i++) c += m_slot[k][i].valid ? 1 : 0;
    return c;
  endfunction

  task automatic m_pixel(input int k, input int px, input int py, input int st,
                         output bit is_b, output int addr);
    bit found = 0;
    addr = 0;
    for (int i = 0; i < NB; i++) begin
      if (!found && m_slot[k][i].valid &&
          px >= m_slot[k][i].x && px < m_slot[k][i].x + 8 &&
          py >= m_slot[k][i].y && py < m_slot[k][i].y + 8) begin
        found = 1;
        addr  = (py - m_slot[k][i].y) * 8 + (px - m_slot[k][i].x);
      end
    end
    is_b = found && (st == 5);
  endtask

  // ---------------- DUT access ----------------
  task automatic set_in(input int k, input int st, input bit start, input int sx, input int sy);
    in_st[k] = st; in_start[k] = start; in_sx[k] = sx; in_sy[k] = sy;
    if (k == 0) begin
      bus_a.status = 4'(st); bus_a.start_bullet = start;
      bus_a.soul_x = 10'(sx); bus_a.soul_y = 10'(sy);
    end else begin
      bus_b.status = 4'(st); bus_b.start_bullet = start;
      bus_b.soul_x = 10'(sx); bus_b.soul_y = 10'(sy);
    end
  endtask

  task automatic set_draw(input int k, input int px, input int py);
    if (k == 0) begin bus_a.DrawX = 10'(px); bus_a.DrawY = 10'(py); end
    else        begin bus_b.DrawX = 10'(px); bus_b.DrawY = 10'(py); end
  endtask

  function automatic int dut_count(input int k);
    return (k == 0) ? int'(bus_a.bullet_count) : int'(bus_b.bullet_count);
  endfunction
  function automatic int dut_hit(input int k);
    return (k == 0) ? int'(bus_a.hit) : int'(bus_b.hit);
  endfunction
  function automatic int dut_is(input int k);
    return (k == 0) ? int'(bus_a.is_bullet) : int'(bus_b.is_bullet);
  endfunction
  function automatic int dut_addr(input int k);
    return (k == 0) ? int'(bus_a.bullet_address) : int'(bus_b.bullet_address);
  endfunction

  // One video frame on both DUTs, then compare count and hit to the model.
  task automatic tick();
    m_step(0);
    m_step(1);
    frame_clk = 1; #5;
    frame_clk = 0; #5;
    check("count_a", dut_count(0), m_count(0));
    check("hit_a",   dut_hit(0),   int'(m_hit[0]));
    check("count_b", dut_count(1), m_count(1));
    check("hit_b",   dut_hit(1),   int'(m_hit[1]));
  endtask

  task automatic pix_exp(input int k, input int px, input int py,
                         input bit e_is, input int e_addr, input string name);
    set_draw(k, px, py);
    #1;
    check({name, "_is"}, dut_is(k), int'(e_is));
    if (e_addr >= 0) check({name, "_addr"}, dut_addr(k), e_addr);
  endtask

  task automatic pix_model(input int k, input int px, input int py);
    bit e_is;
    int e_addr;
    set_draw(k, px, py);
    #1;
    m_pixel(k, px, py, in_st[k], e_is, e_addr);
    check("rnd_is", dut_is(k), int'(e_is));
    if (in_st[k] == 5) check("rnd_addr", dut_addr(k), e_addr);
  endtask

  task automatic pulse_reset(input int k);
    if (k == 0) rst_a = 1; else rst_b = 1;
    #1;
    m_reset(k);
    if (k == 0) rst_a = 0; else rst_b = 0;
    #1;
  endtask

  initial begin
    frame_clk = 0;
    rst_a = 1;
    rst_b = 1;
    m_period[0] = 30;
    m_period[1] = 1;
    for (int k = 0; k < 2; k++) begin
      set_in(k, 0, 0, 0, 0);
      set_draw(k, 0, 0);
      m_reset(k);
    end
    ptab[0] = '{319, 232, 5, 1, 19};
    ptab[1] = '{324, 232, 5, 0, 0};
    ptab[2] = '{319, 232, 4, 0, -1};
    ptab[3] = '{316, 230, 5, 1, 0};
    ptab[4] = '{323, 237, 5, 1, 63};
    ptab[5] = '{323, 238, 5, 0, 0};
    ptab[6] = '{315, 230, 5, 0, 0};
    ptab[7] = '{276, 290, 5, 1, 0};
    ptab[8] = '{283, 297, 5, 1, 63};

    #3;
    for (int k = 0; k < 2; k++) begin
      check("rst_count", dut_count(k), 0);
      check("rst_hit",   dut_hit(k),   0);
      check("rst_is",    dut_is(k),    0);
      check("rst_addr",  dut_addr(k),  0);
    end
    rst_a = 0;
    rst_b = 0;
    #2;

    // ---- spawn timing, pixel table and kill on dut_a (soul far away) ----
    set_in(0, 5, 1, 0, 0);
    for (int t = 1; t <= 156; t++) begin
      tick();
      if (t == 1) begin
        check("t1_count", dut_count(0), 1);
        pix_exp(0, 316, 210, 1, 0, "t1_spawn");
      end
      if (t == 2) begin
        pix_exp(0, 314, 212, 1, 0,  "t2_dx_m2");
        pix_exp(0, 313, 212, 0, 0,  "t2_left");
        pix_exp(0, 321, 219, 1, 63, "t2_corner");
      end
      if (t == 30) check("t30_count", dut_count(0), 1);
      if (t == 31) check("t31_count", dut_count(0), 2);
      if (t == 32) begin
        pix_exp(0, 315, 212, 1, 0, "t32_dx_m1");
        pix_exp(0, 314, 212, 0, 0, "t32_left");
      end
      if (t == 71) begin
        check("t71_count", dut_count(0), 2);
        foreach (ptab[i]) begin
          bus_a.status = 4'(ptab[i].status);
          pix_exp(0, ptab[i].px, ptab[i].py, ptab[i].exp_is, ptab[i].exp_addr, "ptab");
        end
        bus_a.status = 4'd5;
      end
      if (t == 155) check("t155_count", dut_count(0), 4);
      if (t == 156) begin
        check("kill_count", dut_count(0), 3);
        check("kill_hit",   dut_hit(0),   0);
      end
    end
    set_in(0, 0, 0, 0, 0);

    // ---- hit: single pulse, freed slot skipped for the same-frame spawn ----
    pulse_reset(1);
    set_in(1, 5, 1, 0, 0);
    tick();
    tick();
    check("h_t2_count", dut_count(1), 2);
    set_in(1, 5, 1, 300, 220);
    tick();
    check("h_t3_hit",   dut_hit(1),   1);
    check("h_t3_count", dut_count(1), 2);
    pix_exp(1, 312, 214, 0, 0, "h_t3_cleared");
    pix_exp(1, 316, 210, 1, 0, "h_t3_spawn");
    set_in(1, 5, 1, 0, 0);
    tick();
    check("h_t4_hit",   dut_hit(1),   0);
    check("h_t4_count", dut_count(1), 3);
    pix_exp(1, 316, 210, 1, 0,  "h_t4_reuse");
    pix_exp(1, 316, 212, 1, 16, "h_t4_prio");

    // ---- pool fill with 1-frame period; direction frozen while full ----
    pulse_reset(1);
    set_in(1, 5, 1, 0, 0);
    for (int t = 1; t <= 42; t++) begin
      tick();
      if (t <= 8)             check("fill_count", dut_count(1), t);
      if (t >= 9 && t <= 39)  check("full_count", dut_count(1), 8);
      if (t == 40)            check("t40_count",  dut_count(1), 7);
      if (t == 41)            check("t41_count",  dut_count(1), 8);
      if (t == 42) begin
        pix_exp(1, 317, 212, 1, 0, "frozen_dir");
        pix_exp(1, 316, 212, 0, 0, "frozen_left");
      end
    end

    // ---- asynchronous reset with 3 live pellets ----
    pulse_reset(1);
    set_in(1, 5, 1, 0, 0);
    tick();
    tick();
    tick();
    check("ar_pre_count", dut_count(1), 3);
    pix_exp(1, 316, 210, 1, 0, "ar_pre");
    #2;
    rst_b = 1;
    #1;
    check("ar_count", dut_count(1), 0);
    check("ar_hit",   dut_hit(1),   0);
    check("ar_is",    dut_is(1),    0);
    check("ar_addr",  dut_addr(1),  0);
    m_reset(1);
    rst_b = 0;
    #1;

    // ---- randomized run against the model on both DUTs ----
    pulse_reset(0);
    pulse_reset(1);
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < 2; k++) begin
        int st;
        st = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 15)) : 5;
        set_in(k, st, $urandom_range(0, 29) != 0,
               int'($urandom_range(270, 350)), int'($urandom_range(200, 330)));
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < 3; s++) begin
          int j;
          j = int'($urandom_range(0, NB - 1));
          if (m_slot[k][j].valid)
            pix_model(k, m_slot[k][j].x + int'($urandom_range(0, 10)) - 1,
                         m_slot[k][j].y + int'($urandom_range(0, 10)) - 1);
          else
            pix_model(k, int'($urandom_range(230, 410)), int'($urandom_range(200, 410)));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
